// File: rtl/soc_sim_pkg.sv
// Shared types and default constants for the simulation/board reset sequencer.
package soc_sim_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN,
        DONE
    } rst_seq_state_e;

    localparam int HOLD_CYCLES_DEF = 25;
    localparam int STAGGER_DEF     = 4;
    localparam int WDOG_LIMIT_DEF  = 1000000;

endpackage

// File: rtl/soc_wdog_cnt.sv
// Progress watchdog counter: clear/enable, saturating, flags the last cycle before the limit.
module soc_wdog_cnt #(
    parameter int W     = 32,
    parameter int LIMIT = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    // A limit of zero disables the watchdog entirely.
    assign hit = (LIMIT != 0) && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/soc_rst_seq.sv
// Reset sequencer with staggered per-domain release, run cycle counter,
// halt detection and progress watchdog.
module soc_rst_seq
    import soc_sim_pkg::*;
#(
    parameter int NUM_RST     = 2,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int STAGGER     = STAGGER_DEF,
    parameter int CNT_W       = 64,
    parameter int WDOG_W      = 32,
    parameter int WDOG_LIMIT  = WDOG_LIMIT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sw_rst_req,
    input  logic               progress,
    input  logic               halt,
    output logic [NUM_RST-1:0] rst_out,
    output logic               rst_done,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               finish,
    output logic               wdog_timeout
);

    localparam int LAST_REL = HOLD_CYCLES + (NUM_RST - 1) * STAGGER;
    localparam int HOLD_W   = (LAST_REL > 0) ? $clog2(LAST_REL + 1) : 1;

    if (NUM_RST < 1 || NUM_RST > 8) begin : g_bad_num_rst
        $error("soc_rst_seq: NUM_RST must be in 1..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("soc_rst_seq: HOLD_CYCLES must be at least 1");
    end

    rst_seq_state_e     state, state_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt, hold_step;
    logic [NUM_RST-1:0] rst_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               done_nxt, finish_nxt, wdog_nxt;
    logic               wd_clr, wd_en, wd_hit;

    function automatic logic [HOLD_W-1:0] rel_at(input int i);
        return HOLD_W'(HOLD_CYCLES + i * STAGGER);
    endfunction

    soc_wdog_cnt #(
        .W     (WDOG_W),
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clock (clock),
        .reset (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .hit   (wd_hit)
    );

    assign hold_step = hold_cnt + HOLD_W'(1);

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        rst_nxt    = rst_out;
        done_nxt   = rst_done;
        cnt_nxt    = cycle_cnt;
        finish_nxt = finish;
        wdog_nxt   = wdog_timeout;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;

        case (state)
            ASSERT, RELEASE: begin
                // Each domain drops on the edge its release slot is reached,
                // so the last drop and rst_done land on the same edge.
                hold_nxt = hold_step;
                for (int i = 0; i < NUM_RST; i++) begin
                    if (hold_step == rel_at(i)) rst_nxt[i] = 1'b0;
                end
                if (hold_step == HOLD_W'(LAST_REL)) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end else if (hold_step >= HOLD_W'(HOLD_CYCLES)) begin
                    state_nxt = RELEASE;
                end
            end

            RUN: begin
                cnt_nxt = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
                wd_clr  = progress;
                wd_en   = !progress;
                if (halt) begin
                    finish_nxt = 1'b1;
                    state_nxt  = DONE;
                end else if (wd_hit && !progress) begin
                    wdog_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (sw_rst_req) begin
                    // Warm reset keeps cycle_cnt; it just stops advancing until RUN.
                    state_nxt = ASSERT;
                    hold_nxt  = '0;
                    rst_nxt   = '1;
                    done_nxt  = 1'b0;
                    wd_clr    = 1'b1;
                    wd_en     = 1'b0;
                end
            end

            DONE: begin
            end

            default: begin
                state_nxt = ASSERT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ASSERT;
            hold_cnt     <= '0;
            rst_out      <= '1;
            rst_done     <= 1'b0;
            cycle_cnt    <= '0;
            finish       <= 1'b0;
            wdog_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            rst_out      <= rst_nxt;
            rst_done     <= done_nxt;
            cycle_cnt    <= cnt_nxt;
            finish       <= finish_nxt;
            wdog_timeout <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_soc_rst_seq.sv
// Bench for soc_rst_seq: directed scenarios plus randomized traffic against a behavioural model.
module tb_soc_rst_seq;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic sw[2], prog[2], hlt[2];

    logic [1:0]  ro0;
    logic [3:0]  ro1;
    logic        dn0, dn1, f0, f1, w0, w1;
    logic [63:0] cc0;
    logic [3:0]  cc1;

    soc_rst_seq #(.NUM_RST(2), .HOLD_CYCLES(25), .STAGGER(4), .CNT_W(64),
                  .WDOG_W(32), .WDOG_LIMIT(10)) u0 (
        .clock(clock), .reset(reset), .sw_rst_req(sw[0]), .progress(prog[0]),
        .halt(hlt[0]), .rst_out(ro0), .rst_done(dn0), .cycle_cnt(cc0),
        .finish(f0), .wdog_timeout(w0));

    soc_rst_seq #(.NUM_RST(4), .HOLD_CYCLES(25), .STAGGER(0), .CNT_W(4),
                  .WDOG_W(8), .WDOG_LIMIT(0)) u1 (
        .clock(clock), .reset(reset), .sw_rst_req(sw[1]), .progress(prog[1]),
        .halt(hlt[1]), .rst_out(ro1), .rst_done(dn1), .cycle_cnt(cc1),
        .finish(f1), .wdog_timeout(w1));

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: per instance, k = edges since the sequence (re)started; the
    // domain schedule follows directly from k, then a run/terminated phase.
    int nr[2], hd[2], st[2], wl[2];
    longint unsigned cmax[2];
    int k[2], wd[2];
    bit seq[2], term[2], mfin[2], mwdt[2];
    longint unsigned mcnt[2];
    bit mvalid = 1'b0;

    initial begin
        nr[0] = 2; hd[0] = 25; st[0] = 4; wl[0] = 10; cmax[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        nr[1] = 4; hd[1] = 25; st[1] = 0; wl[1] = 0;  cmax[1] = 64'd15;
    end

    always @(posedge clock) begin
        for (int j = 0; j < 2; j++) begin
            if (reset) begin
                k[j] = 0; wd[j] = 0; seq[j] = 1; term[j] = 0;
                mcnt[j] = 0; mfin[j] = 0; mwdt[j] = 0;
            end else if (term[j]) begin
            end else if (seq[j]) begin
                k[j]++;
                if (k[j] == hd[j] + (nr[j] - 1) * st[j]) seq[j] = 0;
            end else begin
                if (mcnt[j] < cmax[j]) mcnt[j]++;
                if (hlt[j]) begin
                    mfin[j] = 1; term[j] = 1;
                end else if (!prog[j] && wl[j] != 0 && wd[j] + 1 == wl[j]) begin
                    mwdt[j] = 1; term[j] = 1;
                end else if (sw[j]) begin
                    seq[j] = 1; k[j] = 0; wd[j] = 0;
                end else begin
                    wd[j] = prog[j] ? 0 : wd[j] + 1;
                end
            end
        end
        if (reset) mvalid = 1'b1;
    end

    function automatic logic [7:0] exp_rst(input int j);
        logic [7:0] r;
        r = '0;
        if (seq[j])
            for (int i = 0; i < nr[j]; i++) r[i] = (k[j] < hd[j] + i * st[j]);
        return r;
    endfunction

    always @(posedge clock) begin
        #1;
        if (mvalid) begin
            check("m_rst_out0",  {56'd0, 6'd0, ro0}, {56'd0, exp_rst(0)});
            check("m_rst_done0", {63'd0, dn0}, {63'd0, !seq[0]});
            check("m_cycle0",    cc0, mcnt[0]);
            check("m_finish0",   {63'd0, f0}, {63'd0, mfin[0]});
            check("m_wdog0",     {63'd0, w0}, {63'd0, mwdt[0]});
            check("m_rst_out1",  {56'd0, 4'd0, ro1}, {56'd0, exp_rst(1)});
            check("m_rst_done1", {63'd0, dn1}, {63'd0, !seq[1]});
            check("m_cycle1",    {60'd0, cc1}, mcnt[1]);
            check("m_finish1",   {63'd0, f1}, {63'd0, mfin[1]});
            check("m_wdog1",     {63'd0, w1}, {63'd0, mwdt[1]});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done0(input string nm);
        int t = 0;
        while (!dn0 && t < 100) begin tick(1); t++; end
        check(nm, {63'd0, dn0}, 64'd1);
    endtask

    task automatic wait_cnt0(input string nm, input logic [63:0] target);
        int t = 0;
        while (cc0 != target && t < 300) begin tick(1); t++; end
        check(nm, cc0, target);
    endtask

    initial begin
        int t;
        int pth;
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin sw[j] = 0; prog[j] = 0; hlt[j] = 0; end
        tick(3);
        check("reset_rst_out0", {62'd0, ro0}, 64'h3);
        check("reset_cycle0", cc0, 64'd0);
        reset = 1'b0;

        // Default release schedule and simultaneous release
        tick(24);
        check("e24_rst_out1", {60'd0, ro1}, 64'hF);
        check("e24_done1", {63'd0, dn1}, 64'd0);
        tick(1);
        check("e25_rst_out0", {62'd0, ro0}, 64'h2);
        check("e25_rst_out1", {60'd0, ro1}, 64'h0);
        check("e25_done1", {63'd0, dn1}, 64'd1);
        tick(3);
        check("e28_rst_out0", {62'd0, ro0}, 64'h2);
        tick(1);
        check("e29_rst_out0", {62'd0, ro0}, 64'h0);
        check("e29_done0", {63'd0, dn0}, 64'd1);
        check("e29_cycle0", cc0, 64'd0);

        // Watchdog: progress at RUN cycle 5, then starve
        tick(4);
        prog[0] = 1; tick(1); prog[0] = 0;
        t = 0;
        while (!w0 && t < 40) begin tick(1); t++; end
        check("wdog_trip", {63'd0, w0}, 64'd1);
        check("wdog_cycle", cc0, 64'd15);
        check("wdog_no_finish", {63'd0, f0}, 64'd0);
        check("sat_cycle1", {60'd0, cc1}, 64'd15);
        sw[0] = 1; tick(1); sw[0] = 0; tick(2);
        check("done_sw_ignored", {62'd0, ro0}, 64'h0);
        check("done_frozen_cnt", cc0, 64'd15);

        // Halt and watchdog trip in the same cycle: halt wins
        reset = 1; tick(1); reset = 0;
        wait_done0("b_done");
        wait_cnt0("b_cnt9", 64'd9);
        hlt[0] = 1; tick(1); hlt[0] = 0;
        check("tie_finish", {63'd0, f0}, 64'd1);
        check("tie_wdog", {63'd0, w0}, 64'd0);
        check("tie_cycle", cc0, 64'd10);

        // Warm reset at cycle_cnt 50, then halt at 100
        reset = 1; tick(1); reset = 0;
        prog[0] = 1;
        wait_done0("c_done");
        wait_cnt0("c_cnt49", 64'd49);
        sw[0] = 1; tick(1); sw[0] = 0;
        check("warm_rst_out", {62'd0, ro0}, 64'h3);
        check("warm_done", {63'd0, dn0}, 64'd0);
        check("warm_cycle", cc0, 64'd50);
        tick(24);
        check("warm_e24", {62'd0, ro0}, 64'h3);
        tick(1);
        check("warm_e25", {62'd0, ro0}, 64'h2);
        tick(4);
        check("warm_e29", {62'd0, ro0}, 64'h0);
        check("warm_e29_done", {63'd0, dn0}, 64'd1);
        check("warm_resume", cc0, 64'd50);
        tick(1);
        check("warm_next", cc0, 64'd51);
        wait_cnt0("c_cnt99", 64'd99);
        hlt[0] = 1; tick(1); hlt[0] = 0; prog[0] = 0;
        check("halt_finish", {63'd0, f0}, 64'd1);
        check("halt_cycle", cc0, 64'd100);
        sw[0] = 1; tick(1); sw[0] = 0; tick(3);
        check("halt_sw_ignored", {62'd0, ro0}, 64'h0);
        check("halt_frozen", cc0, 64'd100);

        // Reset in the middle of RELEASE restarts from edge 1
        reset = 1; tick(1); reset = 0;
        tick(26);
        check("mid_rel_rst_out", {62'd0, ro0}, 64'h2);
        reset = 1; tick(1);
        check("mid_reset_rst_out", {62'd0, ro0}, 64'h3);
        check("mid_reset_cycle", cc0, 64'd0);
        reset = 0;
        tick(25);
        check("mid_e25", {62'd0, ro0}, 64'h2);
        tick(4);
        check("mid_e29", {62'd0, ro0}, 64'h0);
        check("mid_e29_done", {63'd0, dn0}, 64'd1);

        // Randomized traffic; progress density varies per segment
        pth = 5;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) pth = $urandom_range(1, 9);
            for (int j = 0; j < 2; j++) begin
                prog[j] = ($urandom_range(0, 9) < pth);
                hlt[j]  = ($urandom_range(0, 599) == 0);
                sw[j]   = ($urandom_range(0, 199) == 0);
            end
            reset = ($urandom_range(0, 999) == 0) ||
                    ((term[0] || term[1]) && ($urandom_range(0, 29) == 0));
            tick(1);
        end
        reset = 0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_rst_seq.md
# soc_rst_seq

Parametrised reset sequencer and run monitor that sits between the simulation or board top and `ysyxSoCTop`. It holds all downstream reset domains for a programmable number of cycles, then releases them one by one with a fixed stagger. It counts run cycles and watches for forward progress. It reports a clean halt or a watchdog timeout, so neither the bench nor the FPGA top needs hard-coded delays or `$finish` timers.

## Interface
Parameters:
- `NUM_RST`, 2: number of downstream reset domains; legal range 1..8.
- `HOLD_CYCLES`, 25: cycles all domains stay in reset after `reset` falls; must be ≥1.
- `STAGGER`, 4: cycles between consecutive domain releases; 0 releases all domains together.
- `CNT_W`, 64: width of the run cycle counter.
- `WDOG_W`, 32: width of the watchdog counter.
- `WDOG_LIMIT`, 1000000: number of progress-free cycles that trips the watchdog; 0 disables it.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `sw_rst_req` in 1: warm-reset request pulse, honoured only in RUN.
- `progress` in 1: commit or retire pulse; clears the watchdog.
- `halt` in 1: end-of-program indication (e.g. ebreak retired).
- `rst_out` out NUM_RST: per-domain reset, active-high; bit 0 releases first.
- `rst_done` out 1: all domains released and the sequencer is in RUN.
- `cycle_cnt` out CNT_W: number of RUN cycles; saturating.
- `finish` out 1: sticky; set on halt.
- `wdog_timeout` out 1: sticky; set when the watchdog trips.

## Operation
- FSM states: ASSERT, RELEASE, RUN, DONE.
- **Reset.** While `reset`=1: state=ASSERT, `rst_out`=all ones, `rst_done`=0, `cycle_cnt`=0, `finish`=0, `wdog_timeout`=0, hold and watchdog counters=0. `reset` overrides every state, including mid-RELEASE and DONE.
- **ASSERT → RELEASE.** In ASSERT, the hold counter increments each cycle. When it reaches HOLD_CYCLES, go to RELEASE.
- **RELEASE.** `rst_out[i]` drops when the hold counter equals HOLD_CYCLES + i·STAGGER. When the last bit drops, go to RUN and assert `rst_done` in the same cycle.
- **Release order.** Released bits never reassert except on ASSERT entry.
- **RUN, cycle counting.** `cycle_cnt` increments every RUN cycle. It saturates at all ones and does not wrap.
- **RUN, watchdog.** `progress`=1 clears the watchdog counter; otherwise it increments. If `WDOG_LIMIT`≠0 and the counter equals WDOG_LIMIT−1 with `progress`=0, set `wdog_timeout` and go to DONE.
- **RUN, halt.** `halt`=1 sets `finish` and goes to DONE.
- **RUN, warm reset.** `sw_rst_req`=1 goes to ASSERT with `rst_out` all ones and the hold and watchdog counters cleared. `cycle_cnt` is preserved and frozen until the next RUN.
- **Priority in RUN** (highest first): `halt`, then watchdog trip, then `sw_rst_req`. Losing events are dropped.
- **DONE.** Terminal: `rst_out` stays all zeros and all outputs are frozen. `sw_rst_req`, `halt` and `progress` are ignored; only `reset` exits.
- **Ignored inputs.** `progress` and `halt` have no effect outside RUN.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- **Release timing.** Let edge k be the k-th rising edge with `reset`=0 (k=1 is the first). `rst_out[i]` is 0 after edge HOLD_CYCLES + i·STAGGER. `rst_done` is 1 after edge HOLD_CYCLES + (NUM_RST−1)·STAGGER.
- **Cycle count.** `cycle_cnt` first reads 1 one edge after `rst_done` rises.
- **Halt latency.** `finish` is visible one edge after the `halt` cycle.
- **Watchdog latency.** `wdog_timeout` is visible after WDOG_LIMIT consecutive progress-free RUN cycles.
- **Warm reset latency.** `rst_out` reasserts one edge after `sw_rst_req`. Re-release follows the same HOLD/STAGGER schedule.

## Structure
- Shared package `soc_sim_pkg`, containing:
  - the `rst_seq_state_e` enum (ASSERT, RELEASE, RUN, DONE);
  - the default constants HOLD_CYCLES_DEF, STAGGER_DEF and WDOG_LIMIT_DEF.
- One sub-module, `soc_wdog_cnt`: a clear/enable counter with a limit-compare output, instantiated once.
- The hold counter width is derived as $clog2(HOLD_CYCLES+(NUM_RST−1)·STAGGER+1).
- Elaboration-time checks on the legal ranges of NUM_RST and HOLD_CYCLES.

## Test plan
- **Default release.** Defaults (NUM_RST=2, HOLD=25, STAGGER=4); `reset`=1 for 3 cycles, then 0 → `rst_out[0]` falls after edge 25, `rst_out[1]` after edge 29, `rst_done`=1 after edge 29.
- **Simultaneous release.** STAGGER=0, NUM_RST=4 → all four bits fall together after edge 25, and `rst_done` rises on the same edge.
- **Halt.** In RUN, pulse `halt` 100 cycles after `rst_done` → `finish`=1, `cycle_cnt`=100 frozen, and later `sw_rst_req` is ignored.
- **Watchdog.** WDOG_LIMIT=10, `progress` pulsed at RUN cycle 5 then held 0 → `wdog_timeout`=1 after RUN cycle 15. With `halt` and the trip landing in the same cycle → `finish`=1 and `wdog_timeout`=0.
- **Warm reset.** `sw_rst_req` at `cycle_cnt`=50 → `rst_out`=all ones next cycle, then re-release on the HOLD/STAGGER schedule; `cycle_cnt` resumes from 50.
- **Reset mid-sequence.** `reset` pulsed during RELEASE (after edge 26) → `rst_out`=all ones and all counters 0, then the full sequence restarts from edge 1.
